uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx_oversampled.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver: parity modes, FSM states
// and the parity check helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // payload_xor is the XOR reduction of the received payload.
    function automatic logic parity_error(input logic payload_xor, input logic par_bit, input int mode);
        logic total;
        total = payload_xor ^ par_bit;
        if (mode == PAR_ODD)
            return ~total;
        else if (mode == PAR_EVEN)
            return total;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every
// CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (at least every clock).
module uart_baud_tick #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + CW'(1);
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with mid-bit sampling, optional parity, 1/2 stop bits
// and a single-entry valid/ready output holding register with overrun reporting.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchroniser, idle-high on reset so no false start is seen.
    logic rx_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    rx_state_t            state_reg, state_next;
    logic [SW-1:0]        sample_cnt_reg, sample_cnt_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 perr_acc_reg, perr_acc_next;
    logic                 ferr_acc_reg, ferr_acc_next;
    logic                 frame_done;
    logic                 done_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            shift_reg      <= '0;
            perr_acc_reg   <= 1'b0;
            ferr_acc_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            shift_reg      <= shift_next;
            perr_acc_reg   <= perr_acc_next;
            ferr_acc_reg   <= ferr_acc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        stop_cnt_next   = stop_cnt_reg;
        shift_next      = shift_reg;
        perr_acc_next   = perr_acc_reg;
        ferr_acc_next   = ferr_acc_reg;
        frame_done      = 1'b0;
        done_ferr       = ferr_acc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_sync_reg) begin
                    state_next      = ST_START;
                    sample_cnt_next = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (sample_cnt_reg == HALF_LAST) begin
                        sample_cnt_next = '0;
                        if (rx_sync_reg) begin
                            state_next = ST_IDLE;
                        end else begin
                            state_next    = ST_DATA;
                            bit_cnt_next  = '0;
                            perr_acc_next = 1'b0;
                            ferr_acc_next = 1'b0;
                        end
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (sample_cnt_reg == FULL_LAST) begin
                        sample_cnt_next = '0;
                        shift_next      = {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            stop_cnt_next = 1'b0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BW'(1);
                        end
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    if (sample_cnt_reg == FULL_LAST) begin
                        sample_cnt_next = '0;
                        perr_acc_next   = parity_error(^shift_reg, rx_sync_reg, PARITY);
                        state_next      = ST_STOP;
                        stop_cnt_next   = 1'b0;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (sample_cnt_reg == FULL_LAST) begin
                        sample_cnt_next = '0;
                        done_ferr       = ferr_acc_reg | ~rx_sync_reg;
                        ferr_acc_next   = done_ferr;
                        if (stop_cnt_reg == STOP_LAST) begin
                            // Return to IDLE at mid-stop so the next start edge is not missed.
                            state_next = ST_IDLE;
                            frame_done = 1'b1;
                        end else begin
                            stop_cnt_next = 1'b1;
                        end
                    end else begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    // A held frame is only replaced when it is being consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (frame_done && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg    <= shift_reg;
                parity_err_reg <= perr_acc_reg;
                frame_err_reg  <= done_ferr;
                rx_valid_reg   <= 1'b1;
            end else if (frame_done) begin
                overrun_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign parity_err  = parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench: two receivers (8N1 and 8E1); frames are pushed as expected
// entries when sent and popped by per-receiver monitors on each accepted frame.
module tb_uart_rx_oversampled;

    localparam int CLK_FREQ = 1536000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       ready0 = 1'b1;
    logic       ready1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(data0), .rx_valid(valid0),
        .rx_ready(ready0), .parity_err(perr0), .frame_err(ferr0),
        .overrun_err(ovr0), .busy(busy0)
    );

    uart_rx_oversampled #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(ready1), .parity_err(perr1), .frame_err(ferr1),
        .overrun_err(ovr1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   ovr_cnt0 = 0;
    int   ovr_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: every accepted frame must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 && ready0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0_unexpected_frame actual=%0h required=none", data0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    $display("dut0 frame data=%02h perr=%0b ferr=%0b", data0, perr0, ferr0);
                    check("dut0_data", data0, e.data);
                    check("dut0_parity_err", perr0, e.perr);
                    check("dut0_frame_err", ferr0, e.ferr);
                end
            end
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1_unexpected_frame actual=%0h required=none", data1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    $display("dut1 frame data=%02h perr=%0b ferr=%0b", data1, perr1, ferr1);
                    check("dut1_data", data1, e.data);
                    check("dut1_parity_err", perr1, e.perr);
                    check("dut1_frame_err", ferr1, e.ferr);
                end
            end
            if (ovr0) ovr_cnt0++;
            if (ovr1) ovr_cnt1++;
        end
    end

    task automatic drive_bit(input int which, input logic v, input int n);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    // A bad stop bit is held low only ~100 clk so the line is high again before
    // the receiver's follow-on start check, which then rejects it as a false start.
    task automatic send_frame(input int which, input logic [7:0] d, input bit par_en,
                              input logic pbit, input bit stop_ok);
        drive_bit(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], BIT_CLKS);
        if (par_en) drive_bit(which, pbit, BIT_CLKS);
        if (stop_ok) begin
            drive_bit(which, 1'b1, BIT_CLKS);
        end else begin
            drive_bit(which, 1'b0, 100);
            drive_bit(which, 1'b1, 60);
        end
    endtask

    task automatic push0(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe;
        q1.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data", data0, 8'h00);
        check("reset_rx_valid", valid0, 1'b0);
        check("reset_parity_err", perr0, 1'b0);
        check("reset_frame_err", ferr0, 1'b0);
        check("reset_overrun_err", ovr0, 1'b0);
        check("reset_busy", busy0, 1'b0);
        check("reset_dut1_valid", valid1, 1'b0);
        check("reset_dut1_busy", busy1, 1'b0);

        // 8N1 0xA5
        push0(8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (200) @(negedge clk);

        // Even parity: 0x3C has four ones, so parity bit 1 is an error, 0 is not
        push1(8'h3C, 1'b1, 1'b0);
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        push1(8'h3C, 1'b0, 1'b0);
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (200) @(negedge clk);

        // Frame error then a clean frame
        push0(8'h55, 1'b0, 1'b1);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        push0(8'h0F, 1'b0, 1'b0);
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        repeat (200) @(negedge clk);

        // False start: 40 clk low pulse
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        check("false_start_busy_high", busy0, 1'b1);
        repeat (30) @(negedge clk);
        rx0 = 1'b1;
        waited = 0;
        while (busy0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("false_start_busy_cleared", busy0, 1'b0);
        repeat (200) @(negedge clk);

        // Overrun: two back-to-back frames with consumer stalled
        ready0 = 1'b0;
        push0(8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        check("overrun_held_data", data0, 8'h11);
        check("overrun_held_valid", valid0, 1'b1);
        check("overrun_pulse_count", ovr_cnt0, 1);
        ready0 = 1'b1;
        repeat (5) @(negedge clk);
        check("overrun_valid_cleared", valid0, 1'b0);
        repeat (200) @(negedge clk);

        // Reset in the middle of 0x33 (start, 1, 1, part of 0)
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b0, 50);
        check("midframe_busy_before_reset", busy0, 1'b1);
        rx0 = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midframe_reset_busy", busy0, 1'b0);
        check("midframe_reset_valid", valid0, 1'b0);
        repeat (2000) @(negedge clk);

        // Receiver recovers on the next start edge
        push0(8'h44, 1'b0, 1'b0);
        send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);

        waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        repeat (20) @(negedge clk);
        check("dut0_queue_drained", q0.size(), 0);
        check("dut1_queue_drained", q1.size(), 0);
        check("dut0_total_overruns", ovr_cnt0, 1);
        check("dut1_total_overruns", ovr_cnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
